// File: rtl/mult_arbiter.sv
// Round-robin arbiter that lets two requesters share one sequential multiplier.
// Define MULT_ARB_WATCHDOG_EN to abort jobs whose multiplier never reports done.
module mult_arbiter #(
  parameter int WIDTH   = 2048,
  parameter int TIMEOUT = 8192
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [WIDTH-1:0]     multiplier0,
  input  logic [WIDTH-1:0]     multiplicand0,
  input  logic [WIDTH-1:0]     multiplier1,
  input  logic [WIDTH-1:0]     multiplicand1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 done0,
  output logic                 done1,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 err,
  output logic                 mul_start,
  output logic [WIDTH-1:0]     mul_multiplier,
  output logic [WIDTH-1:0]     mul_multiplicand,
  input  logic [2*WIDTH-1:0]   mul_product,
  input  logic                 mul_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]         r_state;
  logic               r_winner;   // 1: requester 1 owns the current job
  logic               r_last;     // requester served most recently
  logic               r_gnt0;
  logic               r_gnt1;
  logic               r_done0;
  logic               r_done1;
  logic               r_busy;
  logic               r_mul_start;
  logic [2*WIDTH-1:0] r_product;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_mcand;

  logic               w_any_req;
  logic               w_pick1;
  logic               w_timeout;

  assign w_any_req = req0 | req1;
  // On a tie the requester that was not served last wins.
  assign w_pick1   = req1 & (~req0 | ~r_last);

`ifdef MULT_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd_cnt <= '0;
    end else if (r_state != S_WAIT) begin
      r_wd_cnt <= '0;
    end else if (!w_timeout) begin
      r_wd_cnt <= r_wd_cnt + WD_W'(1);
    end
  end

  // Expires on the TIMEOUT-th WAIT cycle, so RESP follows TIMEOUT+1 cycles after START.
  assign w_timeout = (r_state == S_WAIT) && (r_wd_cnt == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_timeout & ~mul_done;
    end
  end

  assign err = r_err;
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (TIMEOUT > 0);
  assign w_timeout        = 1'b0;
  assign err              = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_winner    <= 1'b0;
      r_last      <= 1'b1;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_busy      <= 1'b0;
      r_mul_start <= 1'b0;
      // NOTE: the wide operand/product registers are reset too, because their
      // post-reset value of zero is externally visible on the ports.
      r_product   <= '0;
      r_mplier    <= '0;
      r_mcand     <= '0;
    end else begin
      // NOTE: pulse outputs default low here and are overridden below; with
      // non-blocking assignments the last write in the block wins cleanly.
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_mul_start <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state     <= S_START;
            r_winner    <= w_pick1;
            r_gnt0      <= ~w_pick1;
            r_gnt1      <= w_pick1;
            r_mul_start <= 1'b1;
            r_busy      <= 1'b1;
            r_mplier    <= w_pick1 ? multiplier1   : multiplier0;
            r_mcand     <= w_pick1 ? multiplicand1 : multiplicand0;
          end
        end

        S_START: begin
          r_state <= S_WAIT;
        end

        S_WAIT: begin
          if (mul_done) begin
            r_state   <= S_RESP;
            r_product <= mul_product;
            r_done0   <= ~r_winner;
            r_done1   <= r_winner;
          end else if (w_timeout) begin
            r_state   <= S_RESP;
            r_product <= '0;
            r_done0   <= ~r_winner;
            r_done1   <= r_winner;
          end
        end

        S_RESP: begin
          r_state <= S_IDLE;
          r_last  <= r_winner;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt0             = r_gnt0;
  assign gnt1             = r_gnt1;
  assign done0            = r_done0;
  assign done1            = r_done1;
  assign busy             = r_busy;
  assign mul_start        = r_mul_start;
  assign product          = r_product;
  assign mul_multiplier   = r_mplier;
  assign mul_multiplicand = r_mcand;

endmodule
